// File: rtl/boid_frame_sequencer_if.sv
// Control/address bundle between the frame sequencer and the boid datapath + state memory.
// The sequencer takes the master side; frame control and datapath take the slave side.
interface boid_frame_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              mem_we;
    logic              r_en_tot;
    logic              acc_clr;
    logic              r_en_itr;
    logic [6:0]        wb_en;

    modport master (
        input  start,
        output busy, done, rd_addr, wr_addr, mem_we,
        output r_en_tot, acc_clr, r_en_itr, wb_en
    );

    modport slave (
        output start,
        input  busy, done, rd_addr, wr_addr, mem_we,
        input  r_en_tot, acc_clr, r_en_itr, wb_en
    );
endinterface

// File: rtl/boid_frame_sequencer.sv
// Frame sequencer: for each boid in index order, latch own state, stream all boids past
// the neighbour accumulators, hold writeback for WB_CYCLES+1 cycles, commit to memory.
module boid_frame_sequencer #(
    parameter int N_BOIDS   = 32,
    parameter int ADDR_W    = 5,
    parameter int WB_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    boid_frame_sequencer_if.master         bus
);
    localparam int WB_W = (WB_CYCLES > 1) ? $clog2(WB_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_BOIDS - 1);
    localparam logic [WB_W-1:0]   LAST_WB  = WB_W'(WB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LATCH,
        S_SCAN,
        S_DRAIN,
        S_WB,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] self_q, self_d;
    logic [ADDR_W-1:0] nbr_q, nbr_d;
    logic [WB_W-1:0]   wb_cnt_q, wb_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic       busy_c;
    logic       done_c;
    logic       mem_we_c;
    logic       r_en_tot_c;
    logic       acc_clr_c;
    logic       r_en_itr_c;
    logic [6:0] wb_en_c;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            self_q    <= '0;
            nbr_q     <= '0;
            wb_cnt_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            self_q    <= self_d;
            nbr_q     <= nbr_d;
            wb_cnt_q  <= wb_cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_d    = state_q;
        self_d     = self_q;
        nbr_d      = nbr_q;
        wb_cnt_d   = wb_cnt_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        mem_we_c   = 1'b0;
        r_en_tot_c = 1'b0;
        acc_clr_c  = 1'b0;
        r_en_itr_c = 1'b0;
        wb_en_c    = 7'h00;

        unique case (state_q)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    self_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rd_addr_d = self_q;
                state_d   = S_LATCH;
            end
            S_LATCH: begin
                r_en_tot_c = 1'b1;
                acc_clr_c  = 1'b1;
                nbr_d      = '0;
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                // rd_addr_q is the address issued last cycle, whose data is on the bus now.
                rd_addr_d  = nbr_q;
                nbr_d      = nbr_q + ADDR_W'(1);
                r_en_itr_c = (nbr_q != '0) && (rd_addr_q != self_q);
                if (nbr_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                r_en_itr_c = (rd_addr_q != self_q);
                wb_cnt_d   = '0;
                state_d    = S_WB;
            end
            S_WB: begin
                wb_en_c  = 7'h7F;
                wb_cnt_d = wb_cnt_q + WB_W'(1);
                if (wb_cnt_q == LAST_WB) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wb_en_c   = 7'h7F;
                mem_we_c  = 1'b1;
                wr_addr_d = self_q;
                if (self_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    self_d  = self_q + ADDR_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset gates outputs combinationally so an in-flight WRITE never reaches memory.
    assign bus.busy     = reset & busy_c;
    assign bus.done     = reset & done_c;
    assign bus.mem_we   = reset & mem_we_c;
    assign bus.r_en_tot = reset & r_en_tot_c;
    assign bus.acc_clr  = reset & acc_clr_c;
    assign bus.r_en_itr = reset & r_en_itr_c;
    assign bus.wb_en    = {7{reset}} & wb_en_c;
    assign bus.rd_addr  = {ADDR_W{reset}} & rd_addr_d;
    assign bus.wr_addr  = {ADDR_W{reset}} & wr_addr_d;

    a_we_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(bus.mem_we && (bus.r_en_tot || bus.r_en_itr || bus.acc_clr)));

    a_done_busy: assert property (@(posedge clk) disable iff (!reset)
        bus.done |-> bus.busy);
endmodule

// File: tb/tb_boid_frame_sequencer.sv
// Bench for boid_frame_sequencer: three instances (defaults, WB_CYCLES=3, N_BOIDS=2)
// checked cycle by cycle against a frame-timing model derived from cycle arithmetic.
module tb_boid_frame_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    boid_frame_sequencer_if #(.ADDR_W(5)) ifa ();
    boid_frame_sequencer_if #(.ADDR_W(5)) ifb ();
    boid_frame_sequencer_if #(.ADDR_W(1)) ifc ();

    boid_frame_sequencer #(.N_BOIDS(32), .ADDR_W(5), .WB_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    boid_frame_sequencer #(.N_BOIDS(32), .ADDR_W(5), .WB_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));
    boid_frame_sequencer #(.N_BOIDS(2), .ADDR_W(1), .WB_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc));

    // Memory model for instance A: read data is the address, valid one cycle later.
    logic [7:0] mem_data_a;
    always @(posedge clk) mem_data_a <= 8'(ifa.rd_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic busy, input logic done,
                                         input logic tot, input logic clr,
                                         input logic itr, input logic we,
                                         input logic [6:0] wbe, input logic [7:0] rd,
                                         input logic [7:0] wr);
        return {3'b000, busy, done, tot, clr, itr, we, wbe, rd, wr};
    endfunction

    function automatic logic [31:0] obs_a();
        return pack(ifa.busy, ifa.done, ifa.r_en_tot, ifa.acc_clr, ifa.r_en_itr,
                    ifa.mem_we, ifa.wb_en, 8'(ifa.rd_addr),
                    ifa.mem_we ? 8'(ifa.wr_addr) : 8'h00);
    endfunction

    function automatic logic [31:0] obs_b();
        return pack(ifb.busy, ifb.done, ifb.r_en_tot, ifb.acc_clr, ifb.r_en_itr,
                    ifb.mem_we, ifb.wb_en, 8'(ifb.rd_addr),
                    ifb.mem_we ? 8'(ifb.wr_addr) : 8'h00);
    endfunction

    function automatic logic [31:0] obs_c();
        return pack(ifc.busy, ifc.done, ifc.r_en_tot, ifc.acc_clr, ifc.r_en_itr,
                    ifc.mem_we, ifc.wb_en, 8'(ifc.rd_addr),
                    ifc.mem_we ? 8'(ifc.wr_addr) : 8'h00);
    endfunction

    // Expected outputs in cycle t of a frame (t=1 is the first LOAD), from the per-boid
    // schedule LOAD, LATCH, n SCAN slots, DRAIN, wb WB slots, WRITE.
    function automatic logic [31:0] model(input int n, input int wb, input int t);
        int per;
        int b;
        int p;
        per = n + 4 + wb;
        if (t == n * per + 1) return pack(1, 1, 0, 0, 0, 0, 7'h00, 8'(n - 1), 8'h00);
        if (t > n * per + 1)  return pack(0, 0, 0, 0, 0, 0, 7'h00, 8'(n - 1), 8'h00);
        b = (t - 1) / per;
        p = (t - 1) % per;
        if (p == 0) return pack(1, 0, 0, 0, 0, 0, 7'h00, 8'(b), 8'h00);
        if (p == 1) return pack(1, 0, 1, 1, 0, 0, 7'h00, 8'(b), 8'h00);
        if (p <= n + 1)
            return pack(1, 0, 0, 0, (p > 2) && (p - 3 != b), 0, 7'h00, 8'(p - 2), 8'h00);
        if (p == n + 2)
            return pack(1, 0, 0, 0, (n - 1) != b, 0, 7'h00, 8'(n - 1), 8'h00);
        if (p <= n + 2 + wb) return pack(1, 0, 0, 0, 0, 0, 7'h7F, 8'(n - 1), 8'h00);
        return pack(1, 0, 0, 0, 0, 1, 7'h7F, 8'(n - 1), 8'(b));
    endfunction

    initial begin
        int          per_a;
        int          per_b;
        int          itr_cnt;
        int          done_cnt;
        int          done_cyc;
        int          ones;
        int          seen[32];
        logic [7:0]  wr_q[$];

        per_a = 32 + 4 + 1;
        per_b = 32 + 4 + 3;
        itr_cnt = 0; done_cnt = 0; done_cyc = -1;
        foreach (seen[i]) seen[i] = 0;

        // Reset held with start high: everything quiet.
        reset = 1'b0;
        ifa.start = 1'b1;
        ifb.start = 1'b0;
        ifc.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_hold_a%0d", i), obs_a(), 32'h0);
            check($sformatf("rst_hold_b%0d", i), obs_b(), 32'h0);
        end

        // Release with start still high: that edge is cycle 0 of a full frame on A.
        reset = 1'b1;
        tick();
        for (int t = 1; t <= 32 * per_a + 2; t++) begin
            check($sformatf("a_cyc%0d", t), obs_a(), model(32, 1, t));
            if (ifa.mem_we) wr_q.push_back(8'(ifa.wr_addr));
            if (ifa.r_en_itr) begin
                itr_cnt++;
                if ((t - 1) / per_a == 5) seen[mem_data_a[4:0]]++;
            end
            if (ifa.done) begin
                done_cnt++;
                done_cyc = t;
            end
            if (t == 50 || t == 600) ifa.start = 1'b1;
            else if (t <= 32 * per_a + 1) ifa.start = 1'($urandom_range(0, 1));
            else ifa.start = 1'b0;
            tick();
        end
        check("a_we_count", 32'(wr_q.size()), 32'd32);
        for (int i = 0; i < 32 && i < wr_q.size(); i++)
            check($sformatf("a_wr_order%0d", i), 32'(wr_q[i]), 32'(i));
        check("a_itr_count", 32'(itr_cnt), 32'd992);
        check("a_done_count", 32'(done_cnt), 32'd1);
        check("a_done_cycle", 32'(done_cyc), 32'd1185);
        ones = 0;
        for (int j = 0; j < 32; j++) if (j != 5 && seen[j] == 1) ones++;
        check("a_self5_skip", 32'(seen[5]), 32'd0);
        check("a_self5_nbrs", 32'(ones), 32'd31);

        // Second frame on A, reset lands in the WRITE cycle of boid 10.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int t = 1; t < 11 * per_a; t++) begin
            check($sformatf("a2_cyc%0d", t), obs_a(), model(32, 1, t));
            tick();
        end
        check("a2_write10", obs_a(), model(32, 1, 11 * per_a));
        reset = 1'b0;
        #1;
        check("a2_rst_in_write", obs_a(), 32'h0);
        tick();
        reset = 1'b1;
        #1;
        check("a2_idle_after_rst", obs_a(), 32'h0);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        check("a2_restart_load", obs_a(), model(32, 1, 1));

        // Instance B, WB_CYCLES=3: writeback held 4 cycles with the write on the last.
        ifb.start = 1'b1;
        tick();
        for (int t = 1; t <= 32 * per_b + 2; t++) begin
            check($sformatf("b_cyc%0d", t), obs_b(), model(32, 3, t));
            ifb.start = (t <= 32 * per_b + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end

        // Instance C, N_BOIDS=2 with start held: done at 15, idle at 16, reloads at 17.
        ifc.start = 1'b1;
        tick();
        for (int t = 1; t <= 16; t++) begin
            check($sformatf("c_cyc%0d", t), obs_c(), model(2, 1, t));
            tick();
        end
        check("c_restart_load", obs_c(), model(2, 1, 1));
        ifc.start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/boid_frame_sequencer.md
# boid_frame_sequencer

Control sequencer for the boid update datapath. Runs one frame update per `start`: for each boid it latches the boid's own state, streams every other boid past the datapath's neighbour accumulators, holds writeback, then commits the new state to boid memory. It sits between the frame-level control (VGA vsync/HPS start) and the boid datapath plus the M10K boid state memory. It generates only addresses and enables; boid data flows memory → datapath directly.

## Interface
- `N_BOIDS`, 32: boids in memory (≥2).
- `ADDR_W`, 5: memory address width, ≥ clog2(N_BOIDS).
- `WB_CYCLES`, 1: settle cycles for the combinational writeback path before commit (≥1).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low (0 = reset).
- `start` in 1: begin frame update; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame completion.
- `rd_addr` out ADDR_W: boid memory read address; read data valid the following cycle.
- `wr_addr` out ADDR_W: boid memory write address.
- `mem_we` out 1: boid memory write enable (x/y/vx/vy written together).
- `r_en_tot` out 1: latch own-boid state into datapath.
- `acc_clr` out 1: clear datapath accumulators and neighbour counter.
- `r_en_itr` out 1: accumulate current read data as a neighbour candidate.
- `wb_en` out 7: writeback gating; all bits driven identically.

## Operation
- States: IDLE, LOAD, LATCH, SCAN, DRAIN, WB, WRITE, DONE. Internal `self_idx` (boid being updated), `nbr_idx` (scan address), `wb_cnt`.
- IDLE: all outputs 0. `start`=1 → LOAD, `self_idx`=0.
- LOAD (1 cycle): `rd_addr`=`self_idx` → LATCH.
- LATCH (1 cycle): `r_en_tot`=1, `acc_clr`=1; `nbr_idx`=0 → SCAN.
- SCAN (N_BOIDS cycles): `rd_addr`=`nbr_idx`, `nbr_idx`++. Each cycle after the first, `r_en_itr`=1 iff the address issued the previous cycle ≠ `self_idx`. When the issued address is N_BOIDS−1 → DRAIN.
- DRAIN (1 cycle): `r_en_itr`=1 iff N_BOIDS−1 ≠ `self_idx` → WB, `wb_cnt`=0.
- WB (WB_CYCLES cycles): `wb_en`=7'h7F. On the last cycle → WRITE.
- WRITE (1 cycle): `wb_en`=7'h7F (held so datapath outputs remain valid), `mem_we`=1, `wr_addr`=`self_idx`. If `self_idx`=N_BOIDS−1 → DONE, else `self_idx`++ → LOAD.
- DONE (1 cycle): `done`=1, `busy`=1 → IDLE.
- Outputs not listed for a state are 0; `rd_addr`/`wr_addr` hold their last value.
- The self slot produces no `r_en_itr`. Every other boid produces exactly one `r_en_itr` pulse per self boid.
- Boids are updated in place, in index order. Later boids observe already-updated earlier boids; this is intended.
- `start` while busy is ignored. `start` held high in IDLE after DONE starts a new frame.
- `reset`=0 in any state: next state IDLE, counters 0, all outputs 0, no write issued that cycle even if in WRITE.

## Timing
- Per boid: 1 (LOAD) + 1 (LATCH) + N_BOIDS (SCAN) + 1 (DRAIN) + WB_CYCLES + 1 (WRITE) = N_BOIDS+4+WB_CYCLES cycles.
- Frame: `start` sampled at cycle 0. The first LOAD is at cycle 1. `done` is at cycle N_BOIDS·(N_BOIDS+4+WB_CYCLES)+1. With defaults: LOAD at cycle 1, `done` at cycle 1185, `busy` low from cycle 1186.
- Read latency is fixed at 1: `r_en_tot`/`r_en_itr` are asserted in the cycle the data addressed one cycle earlier is on the read bus.
- `mem_we` never coincides with `r_en_tot`, `r_en_itr`, or `acc_clr`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `start`=1 → all outputs 0, `busy`=0. Release with `start`=1 → `busy`=1 next cycle, `rd_addr`=0.
- Full frame, defaults: single `start` pulse → exactly 32 `mem_we` pulses with `wr_addr` 0..31 in order, 32·31=992 `r_en_itr` pulses, and `done` at cycle 1185.
- Self-skip: during the `self_idx`=5 pass, `r_en_itr` is low in exactly the cycle following `rd_addr`=5 and high in the other 31 accumulate slots. Check with the memory model returning the address as data.
- Writeback hold, WB_CYCLES=3: `wb_en`=7'h7F for 4 consecutive cycles, with `mem_we` only in the 4th. `r_en_itr` and `r_en_tot` are low throughout.
- Reset mid-operation: assert `reset`=0 during a WRITE cycle of boid 10 → no write in that cycle, IDLE next cycle. A new `start` restarts at `self_idx`=0.
- `start` while busy: pulse `start` at cycles 50 and 600 → no effect, single `done` at cycle 1185. N_BOIDS=2 edge: `done` at cycle 2·7+1=15.
